// File: rtl/vg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vg_pkg                                                          |
// | Purpose  : Shared types and constants for the vector-generator state       |
// |            sequencer: sequencer FSM encoding, 4-bit PROM state type,       |
// |            decode window bases and default WAIT/HALT state codes.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vg_pkg;

   // Sequencer control FSM.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      WAIT    = 2'd3
   } seq_fsm_t;

   // State word held in and returned by the state PROM.
   typedef logic [3:0] seq_state_t;

   // First state code of each 4-wide pulse window.
   localparam seq_state_t ST_LATCH_BASE  = 4'd0;
   localparam seq_state_t ST_STB_BASE    = 4'd8;

   // Default special state codes.
   localparam seq_state_t DEF_WAIT_STATE = 4'hA;
   localparam seq_state_t DEF_HALT_STATE = 4'h0;

   // One-hot of (s - base) when s lies in [base, base+3], otherwise zero.
   // The unsigned subtraction wraps for s < base, which keeps it out of range.
   function automatic logic [3:0] onehot_window(input seq_state_t s,
                                                input seq_state_t base);
      seq_state_t off;
      off = s - base;
      onehot_window = (off < 4'd4) ? (4'b0001 << off[1:0]) : 4'b0000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vg_state_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vg_state_decode                                                 |
// | Purpose  : Combinational decode of a sequencer state into the latch and    |
// |            strobe one-hot pulse vectors, gated by an enable.               |
// | Ports    : en        in  1  decode enable (CAPTURE step)                   |
// |            state_in  in  4  state code to decode                           |
// |            latch_oh  out 4  bit n set for state ST_LATCH_BASE+n            |
// |            stb_oh    out 4  bit n set for state ST_STB_BASE+n              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vg_state_decode
   import vg_pkg::*;
(
   input  logic       en,
   input  logic [3:0] state_in,
   output logic [3:0] latch_oh,
   output logic [3:0] stb_oh
);

   always_comb begin
      latch_oh = 4'b0000;
      stb_oh   = 4'b0000;
      if (en) begin
         latch_oh = onehot_window(state_in, ST_LATCH_BASE);
         stb_oh   = onehot_window(state_in, ST_STB_BASE);
      end
   end

endmodule
`default_nettype wire

// File: rtl/vg_state_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vg_state_seq                                                    |
// | Purpose  : PROM-driven state sequencer for the vector generator. Forms     |
// |            the 256x4 state PROM address {run, op, state}, loads the PROM   |
// |            word as the next state, emits one-clk latch/strobe pulses for   |
// |            the datapath and stalls in the draw-timer wait state.           |
// | Ports    : clk, reset (async, active high)                                 |
// |            go          in  1  start pulse, ignored while running           |
// |            halt_req    in  1  HALT opcode level from the datapath          |
// |            op          in  3  current opcode bits                          |
// |            timer_zero  in  1  draw timer expired                           |
// |            rom_addr    out 8  PROM address                                 |
// |            rom_cs      out 1  PROM read enable (ISSUE)                     |
// |            rom_dout    in  4  PROM data, one clk after address             |
// |            state       out 4  current sequencer state                      |
// |            latch, stb  out 4  one-clk one-hot decode pulses                |
// |            halted      out 1  sequencer idle                               |
// |            busy        out 1  sequencer running                            |
// |            wd_trip     out 1  sticky watchdog trip (VGSEQ_WATCHDOG_EN)     |
// | Options  : VGSEQ_WATCHDOG_EN - 12-bit WAIT watchdog and wd_trip port.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vg_state_seq
   import vg_pkg::*;
#(
   parameter int         STEP_DIV   = 1,
   parameter logic [3:0] WAIT_STATE = DEF_WAIT_STATE,
   parameter logic [3:0] HALT_STATE = DEF_HALT_STATE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       halt_req,
   input  logic [2:0] op,
   input  logic       timer_zero,
   output logic [7:0] rom_addr,
   output logic       rom_cs,
   input  logic [3:0] rom_dout,
   output logic [3:0] state,
   output logic [3:0] latch,
   output logic [3:0] stb,
   output logic       halted,
   output logic       busy
`ifdef VGSEQ_WATCHDOG_EN
   ,
   output logic       wd_trip
`endif
);

   // ------------------------------------------------------------------
   // Clock-enable divider: ce is high on one clk out of every STEP_DIV.
   // ------------------------------------------------------------------
   localparam int             DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             ce;

   assign ce = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_cnt <= '0;
      else if (ce)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   // ------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------
   seq_fsm_t   fsm, fsm_nx;
   seq_state_t state_nx;
   logic [7:0] addr_nx;
   logic       go_pend, go_pend_nx;
   logic       halt_pend, halt_pend_nx;
   logic       capture_fire;
   logic [3:0] dec_latch, dec_stb;

`ifdef VGSEQ_WATCHDOG_EN
   localparam logic [11:0] WD_LIMIT = 12'd4095;
   logic [11:0] wd_cnt, wd_cnt_nx;
   logic        wd_trip_nx;
`endif

   // Pulses decode the word being loaded, so they appear together with
   // the new state value.
   assign capture_fire = (fsm == CAPTURE) && ce;

   vg_state_decode u_decode (
      .en       (capture_fire),
      .state_in (rom_dout),
      .latch_oh (dec_latch),
      .stb_oh   (dec_stb)
   );

   assign halted = (fsm == IDLE);
   assign busy   = (fsm != IDLE);
   assign rom_cs = (fsm == ISSUE);

   always_comb begin
      fsm_nx       = fsm;
      state_nx     = state;
      addr_nx      = rom_addr;
      go_pend_nx   = go_pend;
      halt_pend_nx = halt_pend;
`ifdef VGSEQ_WATCHDOG_EN
      wd_cnt_nx    = (fsm == WAIT) ? wd_cnt : 12'd0;
      wd_trip_nx   = wd_trip;
`endif

      // go is only accepted while idle; a halt request arriving together
      // with go is remembered for the run that go starts.
      if (fsm == IDLE) begin
         if (go)
            go_pend_nx = 1'b1;
         if (go && halt_req)
            halt_pend_nx = 1'b1;
      end else if (halt_req) begin
         halt_pend_nx = 1'b1;
      end

      case (fsm)
         IDLE: begin
            if (ce && go_pend) begin
               fsm_nx     = ISSUE;
               addr_nx    = {1'b1, op, state};
               go_pend_nx = 1'b0;
            end
         end
         ISSUE: begin
            if (ce)
               fsm_nx = CAPTURE;
         end
         CAPTURE: begin
            if (ce) begin
               state_nx = rom_dout;
               if (rom_dout == WAIT_STATE && !timer_zero) begin
                  fsm_nx = WAIT;
               end else if (rom_dout == HALT_STATE && halt_pend) begin
                  fsm_nx       = IDLE;
                  halt_pend_nx = 1'b0;
               end else begin
                  fsm_nx  = ISSUE;
                  addr_nx = {1'b1, op, rom_dout};
               end
            end
         end
         WAIT: begin
            if (ce) begin
               if (timer_zero) begin
                  fsm_nx  = ISSUE;
                  addr_nx = {1'b1, op, state};
`ifdef VGSEQ_WATCHDOG_EN
                  wd_cnt_nx = 12'd0;
               end else if (wd_cnt == WD_LIMIT - 12'd1) begin
                  // This ce is the WD_LIMIT-th one spent waiting.
                  fsm_nx     = ISSUE;
                  addr_nx    = {1'b1, op, state};
                  wd_trip_nx = 1'b1;
                  wd_cnt_nx  = 12'd0;
               end else begin
                  wd_cnt_nx = wd_cnt + 12'd1;
`endif
               end
            end
         end
         default: fsm_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm       <= IDLE;
         state     <= '0;
         rom_addr  <= '0;
         latch     <= '0;
         stb       <= '0;
         go_pend   <= 1'b0;
         halt_pend <= 1'b0;
      end else begin
         fsm       <= fsm_nx;
         state     <= state_nx;
         rom_addr  <= addr_nx;
         latch     <= dec_latch;
         stb       <= dec_stb;
         go_pend   <= go_pend_nx;
         halt_pend <= halt_pend_nx;
      end
   end

`ifdef VGSEQ_WATCHDOG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt  <= 12'd0;
         wd_trip <= 1'b0;
      end else begin
         wd_cnt  <= wd_cnt_nx;
         wd_trip <= wd_trip_nx;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vg_state_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vg_state_seq                                                 |
// | Purpose  : Self-checking bench for vg_state_seq. A programmable 256x4      |
// |            PROM model feeds a STEP_DIV=1 and a STEP_DIV=4 instance. A      |
// |            step-level reference model queues expected PROM addresses and   |
// |            decode pulses with their clock numbers; a monitor pops them.    |
// | Options  : VGSEQ_WATCHDOG_EN - adds the watchdog scenario.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vg_state_seq;

   logic       clk = 1'b0;
   logic       reset, go, halt_req, timer_zero;
   logic [2:0] op;
   logic [7:0] rom_addr, rom_addr4;
   logic       rom_cs, rom_cs4;
   logic [3:0] rom_dout, rom_dout4, state, state4, latch, latch4, stb, stb4;
   logic       halted, halted4, busy, busy4;
`ifdef VGSEQ_WATCHDOG_EN
   logic       wd_trip, wd_trip4;
`endif

   logic [3:0] tbl [256];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // PROM model: registered read, one clk latency.
   always @(posedge clk) begin
      if (rom_cs)  rom_dout  <= tbl[rom_addr];
      if (rom_cs4) rom_dout4 <= tbl[rom_addr4];
   end

   vg_state_seq #(.STEP_DIV(1)) dut (
      .clk(clk), .reset(reset), .go(go), .halt_req(halt_req), .op(op),
      .timer_zero(timer_zero), .rom_addr(rom_addr), .rom_cs(rom_cs),
      .rom_dout(rom_dout), .state(state), .latch(latch), .stb(stb),
      .halted(halted), .busy(busy)
`ifdef VGSEQ_WATCHDOG_EN
      , .wd_trip(wd_trip)
`endif
   );

   vg_state_seq #(.STEP_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .go(go), .halt_req(halt_req), .op(op),
      .timer_zero(timer_zero), .rom_addr(rom_addr4), .rom_cs(rom_cs4),
      .rom_dout(rom_dout4), .state(state4), .latch(latch4), .stb(stb4),
      .halted(halted4), .busy(busy4)
`ifdef VGSEQ_WATCHDOG_EN
      , .wd_trip(wd_trip4)
`endif
   );

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   typedef struct {
      bit         is_pulse;
      logic [7:0] addr;
      logic [3:0] st;
      logic [7:0] pulse;   // {latch, stb}
      int         cyc;
   } ev_t;

   ev_t        exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   bit         mon_en   = 1'b1;
   logic [3:0] m_state  = 4'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at clk %0d", name, act, req, cyc);
      end
   endtask

   // Step-level model (STEP_DIV=1): step k issues at ti+2k and its decode
   // pulse (if the new state has one) appears two clks later.
   task automatic model_run(input int ti, input logic [2:0] m_op, input int nsteps,
                            input int halt_from, input bit stop_at_wait);
      for (int k = 0; k < nsteps; k++) begin
         ev_t        e;
         logic [3:0] ns;
         e.is_pulse = 1'b0;
         e.addr     = {1'b1, m_op, m_state};
         e.st       = 4'd0;
         e.pulse    = 8'd0;
         e.cyc      = ti + 2 * k;
         exp_q.push_back(e);
         ns = tbl[e.addr];
         if (ns <= 4'd3 || (ns >= 4'd8 && ns <= 4'd11)) begin
            e.is_pulse = 1'b1;
            e.st       = ns;
            e.pulse    = (ns <= 4'd3) ? (8'h10 << ns) : (8'h01 << (ns - 4'd8));
            e.cyc      = ti + 2 * k + 2;
            exp_q.push_back(e);
         end
         m_state = ns;
         if (stop_at_wait && ns == 4'hA) break;
         if (k >= halt_from && ns == 4'h0) break;
      end
   endtask

   // Monitor for the STEP_DIV=1 instance.
   bit prev_cs = 1'b0;
   always @(negedge clk) begin
      ev_t e;
      if (reset || !mon_en) begin
         prev_cs = 1'b0;
      end else begin
         if ((latch | stb) != 4'd0) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_pulse: actual=%0h required=none at clk %0d", {latch, stb}, cyc);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", 1'b1, e.is_pulse);
               check("pulse_bits", {latch, stb}, e.pulse);
               check("pulse_state", state, e.st);
               check("pulse_clk", cyc, e.cyc);
            end
         end
         if (rom_cs && !prev_cs) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_issue: actual=%0h required=none at clk %0d", rom_addr, cyc);
            end else begin
               e = exp_q.pop_front();
               check("issue_kind", 1'b0, e.is_pulse);
               check("issue_addr", rom_addr, e.addr);
               check("issue_clk", cyc, e.cyc);
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++; failures++;
            $display("FAIL missing_event: actual=none required=%0h/%0h due clk %0d", e.addr, e.pulse, e.cyc);
         end
         prev_cs = rom_cs;
      end
   end

   // Monitor for the STEP_DIV=4 instance: ISSUE width and pulse width.
   int run4        = 0;
   bit pulse4_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         run4        = 0;
         pulse4_prev = 1'b0;
      end else begin
         if (rom_cs4) begin
            run4++;
         end else if (run4 != 0) begin
            check("div4_issue_len", run4, 4);
            run4 = 0;
         end
         if (pulse4_prev) check("div4_pulse_width", {latch4, stb4}, 8'd0);
         pulse4_prev = ((latch4 | stb4) != 4'd0);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int t0, n, w, cnt, c;
      reset = 1'b1; go = 1'b0; halt_req = 1'b0; op = 3'd0; timer_zero = 1'b1;
      for (int i = 0; i < 256; i++) tbl[i] = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_rom_addr", rom_addr, 8'd0);
      check("rst_rom_cs", rom_cs, 1'b0);
      check("rst_state", state, 4'd0);
      check("rst_pulses", {latch, stb}, 8'd0);
      check("rst_halted", halted, 1'b1);
      check("rst_busy", busy, 1'b0);
      #2 reset = 1'b0;

      // Basic chain 0->1->8->2->0, halt requested at state 1, extra go ignored.
      tbl[8'h80] = 4'd1; tbl[8'h81] = 4'd8; tbl[8'h88] = 4'd2; tbl[8'h82] = 4'd0;
      @(negedge clk);
      t0 = cyc + 1; go = 1'b1; op = 3'd0;
      model_run(t0 + 1, 3'd0, 8, 1, 1'b0);
      @(negedge clk); go = 1'b0;
      repeat (3) @(negedge clk);
      halt_req = 1'b1; go = 1'b1;
      @(negedge clk); go = 1'b0;
      @(negedge clk); halt_req = 1'b0;
      repeat (3) @(negedge clk);
      check("chain_busy_before_halt", {halted, busy}, 2'b01);
      @(negedge clk);
      check("chain_halted_at_state0", {halted, busy}, 2'b10);
      repeat (10) @(negedge clk);
      check("chain_queue_drained", exp_q.size(), 0);

      // go and halt_req together from IDLE: 0->5->0 halts at the first 0.
      op = 3'd5; tbl[8'hD0] = 4'd5; tbl[8'hD5] = 4'd0;
      repeat (30) @(negedge clk);
      t0 = cyc + 1; go = 1'b1; halt_req = 1'b1;
      model_run(t0 + 1, 3'd5, 8, 0, 1'b0);
      @(negedge clk); go = 1'b0; halt_req = 1'b0;
      repeat (8) @(negedge clk);
      check("gohalt_halted", halted, 1'b1);
      check("gohalt_queue_drained", exp_q.size(), 0);

      // Wait stall: 0->A holds with timer low, then A->3->0 with halt.
      op = 3'd2; tbl[8'hA0] = 4'hA; tbl[8'hAA] = 4'd3; tbl[8'hA3] = 4'd0;
      repeat (30) @(negedge clk);
      timer_zero = 1'b0;
      t0 = cyc + 1; go = 1'b1;
      model_run(t0 + 1, 3'd2, 8, 1 << 20, 1'b1);
      @(negedge clk); go = 1'b0;
      repeat (50) @(negedge clk);
      check("wait_state_held", state, 4'hA);
      check("wait_busy_no_cs", {busy, rom_cs}, 2'b10);
      c = cyc; timer_zero = 1'b1; halt_req = 1'b1;
      model_run(c + 1, 3'd2, 8, 0, 1'b0);
      @(negedge clk); halt_req = 1'b0;
      repeat (8) @(negedge clk);
      check("wait_halted", halted, 1'b1);
      check("wait_queue_drained", exp_q.size(), 0);

      // Randomized runs, each cut by a reset during CAPTURE.
      for (int r = 0; r < 6; r++) begin
         repeat (30) @(negedge clk);
         for (int i = 0; i < 256; i++) tbl[i] = 4'($urandom);
         op = 3'($urandom);
         t0 = cyc + 1; go = 1'b1;
         model_run(t0 + 1, op, 30, 1 << 20, 1'b0);
         @(negedge clk); go = 1'b0;
         n = $urandom_range(4, 40);
         repeat (n) @(negedge clk);
         w = 0;
         while (!(busy && !rom_cs) && w < 10) begin
            @(negedge clk);
            w++;
         end
         check("capture_found", busy && !rom_cs, 1'b1);
         #2 reset = 1'b1;
         #1;
         check("midrst_pulses", {latch, stb}, 8'd0);
         check("midrst_cs_state", {rom_cs, state}, 5'd0);
         check("midrst_rom_addr", rom_addr, 8'd0);
         check("midrst_halted_busy", {halted, busy}, 2'b10);
         @(negedge clk);
         exp_q.delete();
         m_state = 4'd0;
         #2 reset = 1'b0;
         cnt = 0;
         repeat (20) begin
            @(negedge clk);
            if (rom_cs) cnt++;
         end
         check("idle_no_rom_cs", cnt, 0);
      end

`ifdef VGSEQ_WATCHDOG_EN
      // Watchdog: timer held low in WAIT until the trip forces ISSUE.
      check("wd_trip_clear", wd_trip, 1'b0);
      mon_en = 1'b0;
      for (int i = 0; i < 256; i++) tbl[i] = 4'd0;
      op = 3'd0; tbl[8'h80] = 4'hA; timer_zero = 1'b0;
      t0 = cyc + 1; go = 1'b1;
      @(negedge clk); go = 1'b0;
      w = 0;
      while (!wd_trip && w < 5000) begin
         @(negedge clk);
         w++;
      end
      check("wd_trip_set", wd_trip, 1'b1);
      check("wd_trip_clk", cyc - t0, 4098);
      check("wd_reissue", {rom_cs, rom_addr}, {1'b1, 8'h8A});
      timer_zero = 1'b1;
      #2 reset = 1'b1;
      @(negedge clk); #2 reset = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vg_state_seq.md
Name: vg_state_seq

Overview:
- PROM-driven state sequencer for the vector generator; the initiator and reader side of a 256x4 synchronous state PROM.
- Each step forms the PROM address from the go flag, the current opcode and the current state, then loads the 4-bit PROM word as the next state.
- Decodes each state into one-cycle latch and strobe pulses for the vector datapath, and stalls on draw-timer wait states.

Parameters:
- STEP_DIV, 1, clock-enable divider; sequencer advances one phase every STEP_DIV clocks (1 = every clock).
- WAIT_STATE, 4'hA, state code that stalls until timer_zero is high.
- HALT_STATE, 4'h0, state at which a pending halt takes effect.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  start pulse (one clk); ignored while running
- halt_req  in  1  level; HALT opcode decoded by datapath
- op  in  3  current opcode bits from the datapath instruction latch
- timer_zero  in  1  draw timer expired
- rom_addr  out  8  PROM address {run, op[2:0], state[3:0]}
- rom_cs  out  1  PROM read enable, high during ISSUE
- rom_dout  in  4  PROM data, valid one clk after rom_addr/rom_cs
- state  out  4  current sequencer state
- latch  out  4  one-hot pulse; bit n for state n, n=0..3
- stb  out  4  one-hot pulse; bit n for state 8+n, n=0..3
- halted  out  1  high in IDLE
- busy  out  1  high in ISSUE, CAPTURE or WAIT

Behaviour:
- Reset (async): FSM=IDLE, state=0, rom_addr=0, rom_cs=0, latch=0, stb=0, halted=1, busy=0, halt_pend=0, divider=0.
- Divider: ce pulses once every STEP_DIV clocks. FSM transitions only on ce. Pulses last exactly one clk.
- IDLE: halted=1, rom_cs=0. On go=1 (sampled every clk, no ce needed), latch go_pend. Next ce -> ISSUE with run=1.
- ISSUE: rom_cs=1, rom_addr={1'b1, op, state}. Next ce -> CAPTURE.
- CAPTURE: state <= rom_dout. In the same clk, pulse the decoded output for the NEW value:
  - 0..3 -> latch[n]
  - 8..11 -> stb[n-8]
  - others -> no pulse
- From CAPTURE:
  - new state==WAIT_STATE and timer_zero=0 -> WAIT.
  - else new state==HALT_STATE and halt_pend=1 -> IDLE, clear halt_pend.
  - else -> ISSUE.
- WAIT: hold state, no pulses. When timer_zero=1 on ce -> ISSUE.
- halt_req: sampled every clk while busy; sets halt_pend (sticky until consumed).
- Simultaneous go and halt_req in IDLE: go wins; halt_pend is set and is consumed at the first HALT_STATE reached.
- go while busy: ignored, not queued.
- PROM latency is fixed at 1 clk. The ISSUE->CAPTURE spacing of one ce guarantees valid data for any STEP_DIV>=1.
- State wrap: 4-bit, no arithmetic; the PROM fully defines next state.
- Reset mid-operation: immediate return to IDLE. Any in-flight pulse is cut. No PROM read is issued until a new go.

Optional Feature:
- Macro: VGSEQ_WATCHDOG_EN.
- Defined: 12-bit counter runs in WAIT. If it reaches 4095, force WAIT -> ISSUE and set sticky output wd_trip (1 bit, cleared only by reset). The counter clears on leaving WAIT.
- Undefined: no counter and no wd_trip port; WAIT lasts until timer_zero indefinitely.

Decomposition:
- Package vg_pkg:
  - FSM enum (IDLE, ISSUE, CAPTURE, WAIT)
  - 4-bit state typedef
  - constants ST_LATCH_BASE=0, ST_STB_BASE=8
  - default WAIT_STATE and HALT_STATE values
- Sub-module vg_state_decode: combinational state -> latch/stb one-hot. Instantiated once, gated by the CAPTURE pulse.

Test Plan (bench uses a behavioural 256x4 PROM model with a programmable table):
- Reset then idle: assert reset mid-run at CAPTURE -> outputs zero within the same clk; halted=1; no rom_cs for 20 clks without go.
- Basic chain: table {1,op=0,s=0}->1, s=1->8, s=8->2, s=2->0; go at t0, STEP_DIV=1 -> latch[1] pulse at t0+3, stb[0] at t0+5, latch[2] at t0+7; rom_addr=8'h80,8'h81,8'h88 in successive ISSUEs.
- Wait stall: table maps to 4'hA, timer_zero low 50 clks -> state holds 4'hA with no pulses; timer_zero=1 -> ISSUE next clk with rom_addr={1,op,4'hA}.
- Halt: assert halt_req at a state-1 step; table returns 0 -> IDLE at that CAPTURE; halted=1; latch[0] pulses once.
- Divider: STEP_DIV=4 -> ISSUE-to-CAPTURE spacing is exactly 4 clks; pulses remain 1 clk wide.
- Watchdog (VGSEQ_WATCHDOG_EN): timer_zero held low -> wd_trip rises 4095 ce after WAIT entry, and FSM re-enters ISSUE.
